// File: rtl/axilite_master.sv
// Single-outstanding AXI4-Lite master: turns one valid/ready command into one
// AXI4-Lite read or write and returns the result on a valid/ready response port.
module axilite_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rsp_write_d = cmd_write;
          if (cmd_addr[1:0] != 2'b00) begin
            // Misaligned: answer SLVERR locally, never touch the bus
            rsp_resp_d  = 2'b10;
            rsp_rdata_d = '0;
            state_d     = RSP;
          end else if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_AW_W;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        // AW and W complete independently; leave once both are done
        if (awvalid_q && m_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_B;
      end
      WR_B: begin
        if (m_bvalid) begin
          rsp_resp_d  = m_bresp;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      RD_AR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (m_rvalid) begin
          rsp_rdata_d = m_rdata;
          rsp_resp_d  = m_rresp;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign m_bready  = (state_q == WR_B);
  assign m_rready  = (state_q == RD_R);
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign m_awaddr  = awaddr_q;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wvalid_q;
  assign m_araddr  = araddr_q;
  assign m_arvalid = arvalid_q;

endmodule

// File: tb/tb_axilite_master.sv
// Directed bench for axilite_master: the bench plays the AXI4-Lite slave cycle by cycle.
module tb_axilite_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [31:0] mem_word = 32'h0;

  axilite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0; m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
    m_arready = 0; m_rdata = '0; m_rresp = 0; m_rvalid = 0;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    tick();
    cmd_valid = 0;
  endtask

  task automatic test_reset();
    tick();
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else pass_cnt++;
    chk_cnt++; if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid} !== 6'b0)
      $display("FAIL reset_valids got %b want 000000", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}); else pass_cnt++;
    chk_cnt++; if ({m_awaddr, m_wdata, m_wstrb, m_araddr} !== 100'h0)
      $display("FAIL reset_m_fields got %h want 0", {m_awaddr, m_wdata, m_wstrb, m_araddr}); else pass_cnt++;
    chk_cnt++; if ({rsp_rdata, rsp_resp, rsp_write} !== 35'h0)
      $display("FAIL reset_rsp got %h want 0", {rsp_rdata, rsp_resp, rsp_write}); else pass_cnt++;
  endtask

  task automatic test_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m_awready = 1; m_wready = 1;
    issue(1'b1, a, d, s);
    // accept + 1: AW and W presented together
    chk_cnt++; if (cmd_ready !== 1'b0) $display("FAIL wr_busy got %b want 0", cmd_ready); else pass_cnt++;
    chk_cnt++; if ({m_awvalid, m_wvalid} !== 2'b11) $display("FAIL wr_valids got %b want 11", {m_awvalid, m_wvalid}); else pass_cnt++;
    chk_cnt++; if (m_awaddr !== a) $display("FAIL wr_awaddr got %h want %h", m_awaddr, a); else pass_cnt++;
    chk_cnt++; if (m_wdata !== d) $display("FAIL wr_wdata got %h want %h", m_wdata, d); else pass_cnt++;
    chk_cnt++; if (m_wstrb !== s) $display("FAIL wr_wstrb got %h want %h", m_wstrb, s); else pass_cnt++;
    mem_word = m_wdata;
    tick();
    m_awready = 0; m_wready = 0;
    // accept + 2: B phase
    chk_cnt++; if ({m_awvalid, m_wvalid, m_bready, rsp_valid} !== 4'b0010)
      $display("FAIL wr_bphase got %b want 0010", {m_awvalid, m_wvalid, m_bready, rsp_valid}); else pass_cnt++;
    m_bvalid = 1; m_bresp = 2'b00;
    tick();
    m_bvalid = 0;
    // accept + 3: response
    chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL wr_rsp_valid got %b want 1", rsp_valid); else pass_cnt++;
    chk_cnt++; if ({rsp_write, rsp_resp, rsp_rdata} !== {1'b1, 2'b00, 32'h0})
      $display("FAIL wr_rsp got %h want %h", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0}); else pass_cnt++;
    chk_cnt++; if (m_bready !== 1'b0) $display("FAIL wr_bready_rsp got %b want 0", m_bready); else pass_cnt++;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk_cnt++; if ({cmd_ready, rsp_valid} !== 2'b10) $display("FAIL wr_done got %b want 10", {cmd_ready, rsp_valid}); else pass_cnt++;
  endtask

  task automatic test_read();
    m_arready = 1;
    issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    chk_cnt++; if ({m_arvalid, m_awvalid, m_wvalid} !== 3'b100) $display("FAIL rd_valids got %b want 100", {m_arvalid, m_awvalid, m_wvalid}); else pass_cnt++;
    chk_cnt++; if (m_araddr !== 32'h8) $display("FAIL rd_araddr got %h want 00000008", m_araddr); else pass_cnt++;
    tick();
    m_arready = 0;
    chk_cnt++; if ({m_arvalid, m_rready, rsp_valid} !== 3'b010) $display("FAIL rd_rphase got %b want 010", {m_arvalid, m_rready, rsp_valid}); else pass_cnt++;
    m_rvalid = 1; m_rdata = mem_word; m_rresp = 2'b00;
    tick();
    m_rvalid = 0; m_rdata = 32'h5555_5555;
    chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid got %b want 1", rsp_valid); else pass_cnt++;
    chk_cnt++; if (rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rdata got %h want deadbeef", rsp_rdata); else pass_cnt++;
    chk_cnt++; if ({rsp_write, rsp_resp} !== 3'b000) $display("FAIL rd_resp got %b want 000", {rsp_write, rsp_resp}); else pass_cnt++;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rd_done got %b want 1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_wready_first();
    int bhs = 0;
    m_wready = 1; m_awready = 0;
    issue(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hA);
    chk_cnt++; if ({m_awvalid, m_wvalid} !== 2'b11) $display("FAIL wf_start got %b want 11", {m_awvalid, m_wvalid}); else pass_cnt++;
    tick();
    m_wready = 0; m_bvalid = 1; m_bresp = 2'b11;
    // W done, AW still pending; a stray B must be ignored
    for (int i = 0; i < 3; i++) begin
      if (i == 2) m_awready = 1;
      chk_cnt++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b100)
        $display("FAIL wf_wait%0d got %b want 100", i, {m_awvalid, m_wvalid, m_bready}); else pass_cnt++;
      chk_cnt++; if (m_awaddr !== 32'h10) $display("FAIL wf_awaddr%0d got %h want 00000010", i, m_awaddr); else pass_cnt++;
      if (m_bvalid && m_bready) bhs++;
      tick();
    end
    m_awready = 0; m_bresp = 2'b00;
    chk_cnt++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b001) $display("FAIL wf_bphase got %b want 001", {m_awvalid, m_wvalid, m_bready}); else pass_cnt++;
    if (m_bvalid && m_bready) bhs++;
    tick();
    chk_cnt++; if (m_bready !== 1'b0) $display("FAIL wf_bready_after got %b want 0", m_bready); else pass_cnt++;
    if (m_bvalid && m_bready) bhs++;
    m_bvalid = 0;
    chk_cnt++; if (bhs !== 1) $display("FAIL wf_b_count got %0d want 1", bhs); else pass_cnt++;
    chk_cnt++; if ({rsp_valid, rsp_write, rsp_resp} !== 4'b1100) $display("FAIL wf_rsp got %b want 1100", {rsp_valid, rsp_write, rsp_resp}); else pass_cnt++;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic test_misaligned();
    m_arready = 1;
    issue(1'b0, 32'h0000_0402, 32'h0, 4'h0);
    chk_cnt++; if (m_arvalid !== 1'b0) $display("FAIL mis_arvalid got %b want 0", m_arvalid); else pass_cnt++;
    chk_cnt++; if ({rsp_valid, rsp_write, rsp_resp} !== 4'b1010) $display("FAIL mis_rsp got %b want 1010", {rsp_valid, rsp_write, rsp_resp}); else pass_cnt++;
    chk_cnt++; if (rsp_rdata !== 32'h0) $display("FAIL mis_rdata got %h want 0", rsp_rdata); else pass_cnt++;
    rsp_ready = 1;
    tick();
    rsp_ready = 0; m_arready = 0;
    chk_cnt++; if ({m_arvalid, cmd_ready} !== 2'b01) $display("FAIL mis_done got %b want 01", {m_arvalid, cmd_ready}); else pass_cnt++;
  endtask

  task automatic test_slverr_hold();
    m_arready = 1;
    issue(1'b0, 32'hF000_0000, 32'h0, 4'h0);
    tick();
    m_arready = 0; m_rvalid = 1; m_rdata = 32'hCAFE_0001; m_rresp = 2'b10;
    tick();
    m_rvalid = 1; m_rdata = 32'h0000_FFFF; m_rresp = 2'b00;
    for (int i = 0; i < 5; i++) begin
      chk_cnt++; if ({rsp_valid, cmd_ready, rsp_resp} !== 4'b1010)
        $display("FAIL se_hold%0d got %b want 1010", i, {rsp_valid, cmd_ready, rsp_resp}); else pass_cnt++;
      chk_cnt++; if (rsp_rdata !== 32'hCAFE_0001) $display("FAIL se_rdata%0d got %h want cafe0001", i, rsp_rdata); else pass_cnt++;
      tick();
    end
    m_rvalid = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk_cnt++; if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL se_done got %b want 01", {rsp_valid, cmd_ready}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
    chk_cnt++; if (m_arvalid !== 1'b1) $display("FAIL rm_arvalid got %b want 1", m_arvalid); else pass_cnt++;
    #2 rst_n = 0;
    #1;
    chk_cnt++; if ({m_arvalid, rsp_valid, cmd_ready} !== 3'b001) $display("FAIL rm_async got %b want 001", {m_arvalid, rsp_valid, cmd_ready}); else pass_cnt++;
    chk_cnt++; if (m_araddr !== 32'h0) $display("FAIL rm_araddr got %h want 0", m_araddr); else pass_cnt++;
    tick();
    #3 rst_n = 1;
    tick();
    chk_cnt++; if ({cmd_ready, m_arvalid} !== 2'b10) $display("FAIL rm_release got %b want 10", {cmd_ready, m_arvalid}); else pass_cnt++;
    test_write(32'h0000_000C, 32'h0BAD_F00D, 4'h3);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #22 rst_n = 1;
    test_reset();
    test_write(32'h0000_0008, 32'hDEAD_BEEF, 4'hF);
    test_read();
    test_wready_first();
    test_misaligned();
    test_slverr_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/axilite_master.md
Name: axilite_master

Overview:
- Single-outstanding AXI4-Lite master (initiator).
- Converts a simple valid/ready command port (one read or one write per command) into AXI4-Lite address, data and response channel traffic.
- Returns each result on a valid/ready response port.
- Sits between register-access logic or a test driver and any AXI4-Lite slave in the config-register path.

Parameters:
- DATA_WIDTH, 32, data bus width; fixed at 32 (4 strobe bits).
- ADDR_WIDTH, 32, address bus width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  4  byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  AXI response code
- m_awaddr  out  ADDR_WIDTH  AW address
- m_awvalid  out  1  AW valid
- m_awready  in  1  AW ready
- m_wdata  out  DATA_WIDTH  W data
- m_wstrb  out  4  W strobes
- m_wvalid  out  1  W valid
- m_wready  in  1  W ready
- m_bresp  in  2  B response
- m_bvalid  in  1  B valid
- m_bready  out  1  B ready
- m_araddr  out  ADDR_WIDTH  AR address
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_rdata  in  DATA_WIDTH  R data
- m_rresp  in  2  R response
- m_rvalid  in  1  R valid
- m_rready  out  1  R ready

Behaviour:
- Reset values:
  - state=IDLE.
  - All m_*valid, m_bready, m_rready and rsp_valid = 0.
  - rsp_rdata, rsp_resp, rsp_write and all m_* address/data/strobe outputs = 0.
  - cmd_ready = 1 (IDLE).
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- cmd_ready = (state==IDLE). Accept occurs when cmd_valid && cmd_ready. Command fields are registered on accept.
- Alignment check on accept, cmd_addr[1:0] != 0:
  - No AXI traffic is issued.
  - Next state RSP with rsp_resp=2'b10, rsp_rdata=0, rsp_write=cmd_write.
- Aligned write:
  - Next cycle: m_awvalid=1 and m_wvalid=1 together, with registered addr/data/strb (state WR_AW_W).
  - Each valid drops independently on the cycle after its own handshake (awvalid&&awready, wvalid&&wready).
  - Either order, or both in the same cycle, is legal.
  - Once both handshakes are done, go to WR_B. A handshake completing the second channel moves to WR_B on the next edge.
- WR_B: m_bready=1. On bvalid, latch bresp into rsp_resp, set rsp_rdata=0, go to RSP.
- Aligned read:
  - RD_AR: m_arvalid=1 with registered address, held until arready.
  - Then RD_R: m_rready=1. On rvalid, latch rdata and rresp, go to RSP.
- Valids never deassert before their handshake. Address, data and strobes stay stable while the corresponding valid is high.
- RSP: rsp_valid=1, outputs stable until rsp_ready; on rsp_ready, go to IDLE. The next command can be accepted the cycle after.
- Exactly one transaction is in flight; no new command is accepted until the response is consumed.
- Minimum latency (slave ready immediately, responds 1 cycle after address):
  - write: accept T, AW/W handshake T+1, B at T+2, rsp_valid at T+3.
  - read: same cycle counts as write.
- Beats arriving outside the expected state (B outside WR_B, R outside RD_R) are ignored, because bready/rready are 0 there.
- Async reset mid-transaction forces the reset values immediately. Any partially issued AXI transaction is abandoned; the slave must be reset together with the master.

Test Plan:
- Write addr 0x0000_0008, data 0xDEAD_BEEF, wstrb 0xF, slave OKAY -> one AW+W handshake with those values, rsp_write=1, rsp_resp=0, rsp_valid 3 cycles after accept.
- Read addr 0x0000_0008 after the write above -> AR addr 0x8, rsp_rdata=0xDEAD_BEEF, rsp_resp=0.
- Slave raises wready 3 cycles before awready -> m_wvalid drops after the W handshake, m_awvalid holds until the AW handshake, exactly one B accepted, response OKAY.
- Read addr 0x0000_0402, misaligned -> no arvalid ever asserted, rsp_resp=2'b10, rsp_rdata=0.
- Read out-of-range address, slave returns SLVERR -> rsp_resp=2'b10 propagated. Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0 throughout.
- Assert rst_n=0 while m_arvalid=1 -> m_arvalid and rsp_valid drop asynchronously. After release, cmd_ready=1 and a new write completes normally.
